rbuffer_p: RTL and testbench
============================

Name: rbuffer_p

Overview:
- Parameterised pipeline-register bank carrying Nitems independent 32-bit items through MRLen-1 clocked stages of a processor pipeline (F, D, E, M, ...).
- Each item enters at its own start stage, e.g. PC at fetch, decoded operands at execute.
- Per-stage stall and flush controls from the hazard unit hold or bubble the first MRLen-2 stages.
- Every stage's register contents are exposed on the stream output so downstream logic can tap any item at any stage.

Parameters:
- MRLen, default 5: pipeline length. Stages 0..MRLen-2 are registered, giving MRLen-1 stream taps.
- Nitems, default 10: number of carried items.
- DW, default 32: item width in bits.
- start, default all 0: integer array [Nitems-1:0]. start[i] is the first registered stage of item i; legal range 0..MRLen-2.

Ports:
- clk  input  1  rising-edge clock.
- grst  input  1  asynchronous reset, active-high.
- stall  input  [MRLen-3:0]  stall[k] holds stage k registers.
- flush  input  [MRLen-3:0]  flush[k] clears stage k registers.
- in  input  packed [Nitems-1:0][DW-1:0]  item values sampled at their start stage. Slice Nitems-1 is the MSB of the concatenation.
- stream  output  [Nitems-1:0][MRLen-2:0][DW-1:0]  stream[i][s] is the stage s register of item i.

Behaviour:
- Storage R[i][s] exists only for s >= start[i]. For s < start[i], stream[i][s] is constant 0 and no flop is inferred.
- Next-value source for R[i][s]:
  - s == start[i]: in[i].
  - s > start[i]: R[i][s-1].
- Control applies per stage to all items. For stage k < MRLen-2, evaluated in this priority order:
  1. grst=1: all R become 0 immediately (asynchronous). This holds regardless of clock, including mid-operation.
  2. flush[k]=1 at the clock edge: R[*][k] <= 0. Flush wins over stall.
  3. stall[k]=1: R[*][k] holds its value.
  4. Otherwise R[*][k] loads its next-value source.
- Stages k >= MRLen-2 have no controls and advance every cycle unless in reset.
- Controls act on their own stage only:
  - Stalling stage k does not automatically hold stage k-1 or bubble stage k+1. The hazard unit must assert the matching signals.
  - Stage k+1 keeps advancing and re-captures the held R[k] each cycle.
- Latency:
  - in[i] appears on stream[i][start[i]] one clock after sampling.
  - It then moves one stage per unstalled clock.
- Release of grst is synchronous to the next rising edge: the first load occurs on the first edge with grst=0.
- Simultaneous stall/flush on the same stage resolves to flush.
- Simultaneous controls on different stages are independent.
- Outputs are purely registered; stream has no combinational path from in, stall or flush.

Test Plan:
- Reset/advance (MRLen=5, item 9 start=0, items 0..8 start=2):
  - Assert grst: all stream = 0.
  - Release, drive pc=1,2,3,... one per clock: stream[9][0..3] equals the pc from 1,2,3,4 clocks ago.
  - stream[i][0..1] = 0 for all i<9.
- stall[0] for one cycle with pc counting:
  - stream[9][0] repeats its value for one extra cycle.
  - stream[9][1] shows that value twice.
  - Later stages follow with the duplicate.
- stall[2] for one cycle: stream[i][2] holds for all items (operands and pc alike); stream[*][3] captures the held value twice.
- flush[1] for one cycle: stream[9][1] = 0 on the next cycle, then 0 propagates to stream[9][2] and stream[9][3]. stream[9][0] is unaffected.
- flush[2] and stall[2] together: stream[*][2] = 0, confirming flush priority.
- Assert grst asynchronously mid-stream (between edges): every stream output goes to 0 without a clock edge. Counting restarts after release.

Source files
------------

// File: rtl/rbuffer_p_if.sv
// Bundle of pipeline-register bank controls, item inputs and per-stage taps.
// The hazard unit and item sources drive the master side; the register bank is the slave.
interface rbuffer_p_if #(
  parameter int MRLen  = 5,
  parameter int Nitems = 10,
  parameter int DW     = 32
);
  logic [MRLen-3:0]                       stall;
  logic [MRLen-3:0]                       flush;
  logic [Nitems-1:0][DW-1:0]              in;
  logic [Nitems-1:0][MRLen-2:0][DW-1:0]   stream;

  modport master (
    output stall,
    output flush,
    output in,
    input  stream
  );

  modport slave (
    input  stall,
    input  flush,
    input  in,
    output stream
  );
endinterface

// File: rtl/rbuffer_p.sv
// Pipeline-register bank: Nitems items, each entering at its own start stage and
// advancing one stage per clock, with per-stage stall/flush on the early stages.
module rbuffer_p #(
  parameter int MRLen                = 5,
  parameter int Nitems               = 10,
  parameter int DW                   = 32,
  parameter int start [Nitems-1:0]   = '{default: 0}
) (
  input  logic       clk,
  input  logic       grst,
  rbuffer_p_if.slave bus
);

  // Per-stage load/clear; the last stage has no controls and always advances.
  logic [MRLen-2:0] ld;
  logic [MRLen-2:0] clr;

  always_comb begin
    ld  = '1;
    clr = '0;
    for (int k = 0; k < MRLen-2; k++) begin
      clr[k] = bus.flush[k];
      ld[k]  = ~bus.stall[k];
    end
  end

  for (genvar i = 0; i < Nitems; i++) begin : g_item
    for (genvar s = 0; s < MRLen-1; s++) begin : g_stage
      if (s < start[i]) begin : g_none
        assign bus.stream[i][s] = '0;
      end else begin : g_reg
        logic [DW-1:0] nxt;
        logic [DW-1:0] q;

        if (s == start[i]) begin : g_src_in
          assign nxt = bus.in[i];
        end else begin : g_src_prev
          assign nxt = bus.stream[i][s-1];
        end

        // Flush outranks stall on the same stage.
        always_ff @(posedge clk or posedge grst) begin
          if (grst) begin
            q <= '0;
          end else if (clr[s]) begin
            q <= '0;
          end else if (ld[s]) begin
            q <= nxt;
          end
        end

        assign bus.stream[i][s] = q;
      end
    end
  end

endmodule

// File: tb/tb_rbuffer_p.sv
// Bench for rbuffer_p: item 9 is a PC entering at stage 0, items 0..8 are
// operands entering at stage 2; a stage-rule model is compared every cycle.
module tb_rbuffer_p;
  localparam int MRLen  = 5;
  localparam int Nitems = 10;
  localparam int DW     = 32;
  localparam int NS     = MRLen-1;
  localparam int NC     = MRLen-2;
  localparam int st [Nitems-1:0] = '{0, 2, 2, 2, 2, 2, 2, 2, 2, 2};

  logic clk;
  logic grst;

  rbuffer_p_if #(.MRLen(MRLen), .Nitems(Nitems), .DW(DW)) bus ();

  rbuffer_p #(.MRLen(MRLen), .Nitems(Nitems), .DW(DW), .start(st)) dut (
    .clk  (clk),
    .grst (grst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nprint = 0;
  bit cmp_en = 1'b0;

  logic [DW-1:0] mdl [Nitems][NS];

  // Model: each tap is either absent (0), its item's input, or the previous tap.
  always @(posedge clk or posedge grst) begin
    logic [DW-1:0] old [Nitems][NS];
    if (grst) begin
      for (int i = 0; i < Nitems; i++)
        for (int s = 0; s < NS; s++) mdl[i][s] = '0;
    end else begin
      old = mdl;
      for (int i = 0; i < Nitems; i++) begin
        for (int s = 0; s < NS; s++) begin
          if (s < st[i])                      mdl[i][s] = '0;
          else if (s < NC && bus.flush[s])    mdl[i][s] = '0;
          else if (s < NC && bus.stall[s])    mdl[i][s] = old[i][s];
          else if (s == st[i])                mdl[i][s] = bus.in[i];
          else                                mdl[i][s] = old[i][s-1];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < Nitems; i++) begin
        for (int s = 0; s < NS; s++) begin
          total++;
          if (bus.stream[i][s] !== mdl[i][s]) begin
            bad++;
            if (nprint < 30) begin
              nprint++;
              $display("FAIL model item%0d stage%0d got=%h want=%h t=%0t",
                       i, s, bus.stream[i][s], mdl[i][s], $time);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] opnd(input int p, input int i);
    return 32'hA000_0000 + p*16 + i;
  endfunction

  task automatic drive(input int p, input logic [NC-1:0] stl, input logic [NC-1:0] fl);
    bus.in[9] = p;
    for (int i = 0; i < 9; i++) bus.in[i] = opnd(p, i);
    bus.stall = stl;
    bus.flush = fl;
  endtask

  // Apply inputs, let one rising edge sample them, settle after the falling edge.
  task automatic tick(input int p, input logic [NC-1:0] stl, input logic [NC-1:0] fl);
    drive(p, stl, fl);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < Nitems; i++)
      for (int s = 0; s < NS; s++)
        chk(name, bus.stream[i][s], '0);
  endtask

  initial begin
    for (int i = 0; i < Nitems; i++)
      for (int s = 0; s < NS; s++) mdl[i][s] = '0;
    grst = 1'b1;
    drive(0, '0, '0);
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");

    grst = 1'b0;
    for (int p = 1; p <= 4; p++) tick(p, '0, '0);
    chk("adv s0", bus.stream[9][0], 32'd4);
    chk("adv s1", bus.stream[9][1], 32'd3);
    chk("adv s2", bus.stream[9][2], 32'd2);
    chk("adv s3", bus.stream[9][3], 32'd1);
    chk("op s2", bus.stream[3][2], 32'hA000_0043);
    chk("op s3", bus.stream[3][3], 32'hA000_0033);
    chk("op s0 absent", bus.stream[3][0], '0);
    chk("op s1 absent", bus.stream[0][1], '0);
    tick(5, '0, '0);
    tick(6, '0, '0);

    tick(7, 3'b001, '0);
    chk("stall0 s0", bus.stream[9][0], 32'd6);
    chk("stall0 s1", bus.stream[9][1], 32'd6);
    chk("stall0 s3", bus.stream[9][3], 32'd4);
    tick(8, '0, '0);
    chk("stall0 dup s1", bus.stream[9][1], 32'd6);
    chk("stall0 dup s2", bus.stream[9][2], 32'd6);
    tick(9, '0, '0);
    tick(10, '0, '0);
    chk("pre s3", bus.stream[9][3], 32'd6);

    tick(11, 3'b100, '0);
    chk("stall2 pc s2", bus.stream[9][2], 32'd8);
    chk("stall2 pc s3", bus.stream[9][3], 32'd8);
    chk("stall2 op s2", bus.stream[3][2], 32'hA000_00A3);
    chk("stall2 op s3", bus.stream[3][3], 32'hA000_00A3);
    tick(12, '0, '0);
    chk("stall2 dup s3", bus.stream[9][3], 32'd8);
    chk("stall2 op dup s3", bus.stream[3][3], 32'hA000_00A3);
    chk("stall2 op new s2", bus.stream[3][2], 32'hA000_00C3);

    tick(13, 3'b010, 3'b010);
    chk("flush1 s1", bus.stream[9][1], '0);
    chk("flush1 s0", bus.stream[9][0], 32'd13);
    tick(14, '0, '0);
    chk("flush1 bubble s2", bus.stream[9][2], '0);
    tick(15, '0, '0);
    chk("flush1 bubble s3", bus.stream[9][3], '0);

    tick(16, 3'b100, 3'b100);
    chk("flush2 pc s2", bus.stream[9][2], '0);
    chk("flush2 op s2", bus.stream[3][2], '0);
    chk("flush2 op7 s2", bus.stream[7][2], '0);
    tick(17, '0, '0);
    tick(18, '0, '0);

    #2 grst = 1'b1;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    #1;
    grst = 1'b0;
    for (int p = 1; p <= 4; p++) tick(p, '0, '0);
    chk("restart s0", bus.stream[9][0], 32'd4);
    chk("restart s3", bus.stream[9][3], 32'd1);
    chk("restart op s2", bus.stream[5][2], 32'hA000_0045);

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
